// File: rtl/lmc_tx_striper.sv
// Transmit lane striper: buffers one 64-byte MAC beat and distributes it
// byte-round-robin over the active lanes, one slice of L*B bytes per clk.
//
// state | meaning
// IDLE  | no beat buffered; ready for a new beat, lane outputs idle
// SEND  | emitting slices of the buffered beat; ready again on the last slice
module lmc_tx_striper #(
  parameter int GEN1_PIPEWIDTH = 8,
  parameter int GEN2_PIPEWIDTH = 16,
  parameter int GEN3_PIPEWIDTH = 32,
  parameter int GEN4_PIPEWIDTH = 8,
  parameter int GEN5_PIPEWIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   GEN,
  input  logic [4:0]   LANESNUMBER,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_data,
  input  logic [63:0]  in_datak,
  input  logic [1:0]   in_synchdr,
  output logic [511:0] lane_data,
  output logic [63:0]  lane_datak,
  output logic [15:0]  lane_valid,
  output logic [31:0]  lane_synchdr,
  output logic         lane_sof
);

  typedef enum logic {IDLE, SEND} state_t;

  // log2 of bytes per lane for a PIPE width; unsupported widths fall back to 8 bits
  function automatic logic [1:0] pw_lb(input int pw);
    case (pw)
      16:      return 2'd1;
      32:      return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  localparam logic [1:0] LB1 = pw_lb(GEN1_PIPEWIDTH);
  localparam logic [1:0] LB2 = pw_lb(GEN2_PIPEWIDTH);
  localparam logic [1:0] LB3 = pw_lb(GEN3_PIPEWIDTH);
  localparam logic [1:0] LB4 = pw_lb(GEN4_PIPEWIDTH);
  localparam logic [1:0] LB5 = pw_lb(GEN5_PIPEWIDTH);

  state_t         state, state_nxt;
  logic [511:0]   buf_data;
  logic [63:0]    buf_k;
  logic [1:0]     buf_sh;
  logic [2:0]     ll_q;       // log2 of latched lane count
  logic [1:0]     lb_q;       // log2 of latched bytes per lane
  logic [5:0]     cnt;
  logic [2:0]     cfg_ll;
  logic [1:0]     cfg_lb;
  logic [2:0]     sh_amt;
  logic           last_slice;
  logic           accept;
  logic [11:0]    idx;
  logic [511:0]   slice_data;
  logic [63:0]    slice_k;
  logic [15:0]    slice_valid;
  logic [31:0]    slice_sh;

  // decode the live configuration; illegal values degrade to Gen1 width / x1
  always_comb begin
    cfg_lb = LB1;
    case (GEN)
      3'd2:    cfg_lb = LB2;
      3'd3:    cfg_lb = LB3;
      3'd4:    cfg_lb = LB4;
      3'd5:    cfg_lb = LB5;
      default: cfg_lb = LB1;
    endcase
    cfg_ll = 3'd0;
    case (LANESNUMBER)
      5'd2:    cfg_ll = 3'd1;
      5'd4:    cfg_ll = 3'd2;
      5'd8:    cfg_ll = 3'd3;
      5'd16:   cfg_ll = 3'd4;
      default: cfg_ll = 3'd0;
    endcase
  end

  // N-1 = 63 >> log2(S), so the last slice is a shift compare
  assign sh_amt     = ll_q + {1'b0, lb_q};
  assign last_slice = (cnt == (6'h3F >> sh_amt));

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SEND;
      SEND:    if (last_slice && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // handshake outputs; held not-ready while reset is asserted
  always_comb begin
    in_ready = reset && ((state == IDLE) || last_slice);
    accept   = in_valid && in_ready;
  end

  // gather slice cnt: lane l byte b takes global byte cnt*S + b*L + l
  always_comb begin
    slice_data  = '0;
    slice_k     = '0;
    slice_valid = '0;
    slice_sh    = '0;
    idx         = '0;
    for (int l = 0; l < 16; l++) begin
      if (l < (32'd1 << ll_q)) begin
        slice_valid[l]    = 1'b1;
        slice_sh[2*l +: 2] = buf_sh;
        for (int b = 0; b < 4; b++) begin
          if (b < (32'd1 << lb_q)) begin
            idx = (12'(cnt) << sh_amt) + (12'(b) << ll_q) + 12'(l);
            slice_data[32*l + 8*b +: 8] = buf_data[{idx[5:0], 3'b000} +: 8];
            slice_k[4*l + b]            = buf_k[idx[5:0]];
          end
        end
      end
    end
  end

  // beat buffer, slice counter and registered lane outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_data     <= '0;
      buf_k        <= '0;
      buf_sh       <= '0;
      ll_q         <= '0;
      lb_q         <= '0;
      cnt          <= '0;
      lane_data    <= '0;
      lane_datak   <= '0;
      lane_valid   <= '0;
      lane_synchdr <= '0;
      lane_sof     <= 1'b0;
    end else begin
      if (accept) begin
        buf_data <= in_data;
        buf_k    <= in_datak;
        buf_sh   <= in_synchdr;
        ll_q     <= cfg_ll;
        lb_q     <= cfg_lb;
      end
      if (state == SEND) begin
        lane_data    <= slice_data;
        lane_datak   <= slice_k;
        lane_valid   <= slice_valid;
        lane_synchdr <= slice_sh;
        lane_sof     <= (cnt == 6'd0);
        cnt          <= (accept || last_slice) ? 6'd0 : cnt + 6'd1;
      end else begin
        lane_data    <= '0;
        lane_datak   <= '0;
        lane_valid   <= '0;
        lane_synchdr <= '0;
        lane_sof     <= 1'b0;
        cnt          <= 6'd0;
      end
    end
  end

endmodule

// File: tb/tb_lmc_tx_striper.sv
// Bench for lmc_tx_striper: directed scenarios plus random traffic, checked
// against a queue of expected slices built directly from the striping rule.
module tb_lmc_tx_striper;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   GEN;
  logic [4:0]   LANESNUMBER;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_data;
  logic [63:0]  in_datak;
  logic [1:0]   in_synchdr;
  logic [511:0] lane_data;
  logic [63:0]  lane_datak;
  logic [15:0]  lane_valid;
  logic [31:0]  lane_synchdr;
  logic         lane_sof;

  lmc_tx_striper dut (
    .clk(clk), .reset(reset), .GEN(GEN), .LANESNUMBER(LANESNUMBER),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_datak(in_datak), .in_synchdr(in_synchdr), .lane_data(lane_data),
    .lane_datak(lane_datak), .lane_valid(lane_valid),
    .lane_synchdr(lane_synchdr), .lane_sof(lane_sof)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [511:0] d;
    logic [63:0]  k;
    logic [15:0]  v;
    logic [31:0]  sh;
    logic         sof;
  } slice_t;

  slice_t q[$];
  slice_t cur;
  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // expected slices of one beat, scattering bytes in global order
  task automatic push_beat(input logic [511:0] d, input logic [63:0] k, input logic [1:0] sh,
                           input logic [2:0] gen, input logic [4:0] lanes);
    int pw, bpl, nl, s_bytes, n, s, kk, ln, lb;
    slice_t sl[64];
    case (gen)
      3'd2: pw = 16;
      3'd3: pw = 32;
      default: pw = 8;
    endcase
    bpl = pw / 8;
    nl  = (lanes == 1 || lanes == 2 || lanes == 4 || lanes == 8 || lanes == 16) ? int'(lanes) : 1;
    s_bytes = nl * bpl;
    n = 64 / s_bytes;
    for (int i = 0; i < n; i++) begin
      sl[i] = '0;
      sl[i].sof = (i == 0);
      for (int l = 0; l < nl; l++) begin
        sl[i].v[l] = 1'b1;
        sl[i].sh[2*l +: 2] = sh;
      end
    end
    for (int j = 0; j < 64; j++) begin
      s  = j / s_bytes;
      kk = j % s_bytes;
      ln = kk % nl;
      lb = kk / nl;
      sl[s].d[32*ln + 8*lb +: 8] = d[8*j +: 8];
      sl[s].k[4*ln + lb]         = k[j];
    end
    for (int i = 0; i < n; i++) q.push_back(sl[i]);
  endtask

  // one clock: check ready, advance model on the edge, check lane outputs
  task automatic step(input logic v);
    logic acc;
    in_valid = v;
    #0;
    chk("in_ready", 512'(in_ready), 512'(q.size() <= 1));
    acc = v && (q.size() <= 1);
    @(posedge clk);
    cur = (q.size() != 0) ? q.pop_front() : slice_t'('0);
    if (acc) push_beat(in_data, in_datak, in_synchdr, GEN, LANESNUMBER);
    #1;
    chk("lane_data",    lane_data,          cur.d);
    chk("lane_datak",   512'(lane_datak),   512'(cur.k));
    chk("lane_valid",   512'(lane_valid),   512'(cur.v));
    chk("lane_synchdr", 512'(lane_synchdr), 512'(cur.sh));
    chk("lane_sof",     512'(lane_sof),     512'(cur.sof));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, 512'(in_ready), 512'(0));
    chk({tag, "_data"},  lane_data, 512'(0));
    chk({tag, "_misc"},  512'({lane_datak, lane_valid, lane_synchdr, lane_sof}), 512'(0));
  endtask

  task automatic seq_data;
    for (int j = 0; j < 64; j++) in_data[8*j +: 8] = 8'(j);
  endtask

  task automatic rand_data;
    for (int w = 0; w < 16; w++) in_data[32*w +: 32] = $urandom;
    in_datak   = {$urandom, $urandom};
    in_synchdr = 2'($urandom);
  endtask

  initial begin
    reset = 1'b0; GEN = 3'd1; LANESNUMBER = 5'd1; in_valid = 1'b0;
    in_data = '0; in_datak = '0; in_synchdr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    reset = 1'b1;

    // Gen3 x16: one slice per beat, streamed back-to-back
    GEN = 3'd3; LANESNUMBER = 5'd16; seq_data; in_datak = '0; in_synchdr = 2'b10;
    step(1);
    step(1);
    chk("g3x16_lane5", 512'(lane_data[32*5 +: 32]), 512'(32'h3525_1505));
    step(1);
    step(0);
    step(0);

    // Gen1 x1: 64 single-byte slices
    GEN = 3'd1; LANESNUMBER = 5'd1; seq_data;
    step(1);
    for (int i = 0; i < 64; i++) begin
      step(0);
      chk("g1x1_byte", 512'(lane_data[7:0]), 512'(i));
    end
    step(0);

    // Gen2 x4: K only on byte 9
    GEN = 3'd2; LANESNUMBER = 5'd4; rand_data; in_datak = 64'h200;
    step(1);
    step(0);
    step(0);
    chk("g2x4_k", 512'(lane_datak), 512'(64'h10));
    repeat (7) step(0);

    // illegal lane count 5 behaves as x1
    GEN = 3'd3; LANESNUMBER = 5'd5; rand_data;
    step(1);
    repeat (17) step(0);

    // lane count change mid-beat applies to the next beat only
    GEN = 3'd2; LANESNUMBER = 5'd4; rand_data;
    step(1);
    LANESNUMBER = 5'd8; rand_data;
    repeat (8) step(1);
    in_valid = 1'b0;
    repeat (5) step(0);

    // Gen4 x8 sync header, then reset in the middle of the beat
    GEN = 3'd4; LANESNUMBER = 5'd8; rand_data; in_synchdr = 2'b01;
    step(1);
    step(0);
    chk("g4x8_synchdr", 512'(lane_synchdr), 512'(32'h0000_5555));
    chk("g4x8_sof0", 512'(lane_sof), 512'(1));
    step(0);
    chk("g4x8_sof1", 512'(lane_sof), 512'(0));
    step(0);
    step(0);
    reset = 1'b0;
    #1;
    chk_idle_outputs("midreset");
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(0);

    // random traffic with configuration churn every cycle
    for (int i = 0; i < 400; i++) begin
      GEN = 3'($urandom);
      LANESNUMBER = 5'($urandom_range(0, 20));
      rand_data;
      step(($urandom % 4) != 0);
    end
    in_valid = 1'b0;
    while (q.size() != 0) step(0);
    step(0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
